// File: rtl/address_bank_setter.sv
// address_bank_setter: independent read/write register-bank pointers with set, toggle, wrap-increment and a context stack.
// Latency: a command sampled on a rising edge is visible on every output right after that edge (1 cycle).
// Backpressure: none; one command per cycle is always accepted, illegal commands are dropped and flagged in err.
//
// Ports:
//   single_clk, reset       clock and synchronous active-high reset (reset wins over everything)
//   cmd_valid, cmd, cmd_bank command strobe, 3-bit opcode, target bank for SET_W/SET_R/PUSH
//   err_clear               clears the sticky error bits (a same-cycle new error still sets its bit)
//   write_bank, read_bank   current bank pointers (registered)
//   stack_level             occupied context-stack entries; stack_full / stack_empty decoded from it
//   err                     sticky {range, underflow, overflow}
//
// Build option: define ADDR_SETTER_STACK_EN to build the PUSH/POP context stack. Without it PUSH and
// POP are NOPs, stack_level/stack_full/stack_empty are constant and err[1:0] stays 0.
module address_bank_setter #(
  parameter int BANK_COUNT  = 4,
  parameter int BANK_WIDTH  = 2,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_WIDTH = 3
) (
  input  logic                   single_clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [BANK_WIDTH-1:0]  cmd_bank,
  input  logic                   err_clear,
  output logic [BANK_WIDTH-1:0]  write_bank,
  output logic [BANK_WIDTH-1:0]  read_bank,
  output logic [DEPTH_WIDTH-1:0] stack_level,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic [2:0]             err
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_TOG_W = 3'b001,
    OP_SET_W = 3'b010,
    OP_TOG_R = 3'b011,
    OP_SET_R = 3'b100,
    OP_INC   = 3'b101,
    OP_PUSH  = 3'b110,
    OP_POP   = 3'b111
  } opcode_t;

  localparam logic [BANK_WIDTH-1:0] BANK_ONE  = BANK_WIDTH'(1);
  localparam logic [BANK_WIDTH-1:0] BANK_LAST = BANK_WIDTH'(BANK_COUNT - 1);

  // Pointer width may cover more codes than there are banks; only 0..BANK_COUNT-1 are legal.
  function automatic logic in_range(input logic [BANK_WIDTH-1:0] b);
    return 32'(b) < 32'(BANK_COUNT);
  endfunction

  // Explicit wrap at the last bank so non-power-of-2 bank counts work.
  function automatic logic [BANK_WIDTH-1:0] bank_inc(input logic [BANK_WIDTH-1:0] b);
    return (b == BANK_LAST) ? '0 : b + BANK_ONE;
  endfunction

  opcode_t               op;
  logic [BANK_WIDTH-1:0] write_tog;
  logic [BANK_WIDTH-1:0] read_tog;
  logic [BANK_WIDTH-1:0] write_nxt;
  logic [BANK_WIDTH-1:0] read_nxt;
  logic [2:0]            err_new;
  logic [2:0]            err_nxt;

  assign op        = opcode_t'(cmd);
  assign write_tog = write_bank ^ BANK_ONE;
  assign read_tog  = read_bank ^ BANK_ONE;

`ifdef ADDR_SETTER_STACK_EN
  // Storage is rounded up to a power of two so the slot index is a plain slice of stack_level.
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << PTR_W;
  localparam logic [DEPTH_WIDTH-1:0] LEVEL_ONE = DEPTH_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0] LEVEL_MAX = DEPTH_WIDTH'(STACK_DEPTH);

  logic                   push_go;
  logic                   pop_go;
  logic [DEPTH_WIDTH-1:0] level_dec;
  logic [BANK_WIDTH-1:0]  stack_read  [SLOTS];
  logic [BANK_WIDTH-1:0]  stack_write [SLOTS];

  assign stack_full  = (stack_level == LEVEL_MAX);
  assign stack_empty = (stack_level == '0);
  assign level_dec   = stack_level - LEVEL_ONE;
`else
  assign stack_level = '0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
`endif

  always_comb begin
    write_nxt = write_bank;
    read_nxt  = read_bank;
    err_new   = 3'b000;
`ifdef ADDR_SETTER_STACK_EN
    push_go   = 1'b0;
    pop_go    = 1'b0;
`endif
    if (cmd_valid) begin
      case (op)
        OP_NOP: ;
        OP_TOG_W: begin
          if (in_range(write_tog)) write_nxt = write_tog;
          else                     err_new[2] = 1'b1;
        end
        OP_TOG_R: begin
          if (in_range(read_tog)) read_nxt = read_tog;
          else                    err_new[2] = 1'b1;
        end
        OP_SET_W: begin
          if (in_range(cmd_bank)) write_nxt = cmd_bank;
          else                    err_new[2] = 1'b1;
        end
        OP_SET_R: begin
          if (in_range(cmd_bank)) read_nxt = cmd_bank;
          else                    err_new[2] = 1'b1;
        end
        OP_INC: begin
          write_nxt = bank_inc(write_bank);
          read_nxt  = bank_inc(read_bank);
        end
`ifdef ADDR_SETTER_STACK_EN
        // Full and out-of-range are reported independently; either one blocks the push.
        OP_PUSH: begin
          err_new[0] = stack_full;
          err_new[2] = !in_range(cmd_bank);
          if (!stack_full && in_range(cmd_bank)) begin
            push_go   = 1'b1;
            write_nxt = cmd_bank;
            read_nxt  = cmd_bank;
          end
        end
        OP_POP: begin
          err_new[1] = stack_empty;
          if (!stack_empty) begin
            pop_go    = 1'b1;
            write_nxt = stack_write[level_dec[PTR_W-1:0]];
            read_nxt  = stack_read[level_dec[PTR_W-1:0]];
          end
        end
`endif
        default: ;
      endcase
    end
    // A new error in the clearing cycle still lands in its bit.
    err_nxt = (err_clear ? 3'b000 : err) | err_new;
`ifndef ADDR_SETTER_STACK_EN
    err_nxt[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge single_clk) begin
    if (reset) begin
      write_bank <= '0;
      read_bank  <= '0;
      err        <= 3'b000;
    end else begin
      write_bank <= write_nxt;
      read_bank  <= read_nxt;
      err        <= err_nxt;
    end
  end

`ifdef ADDR_SETTER_STACK_EN
  always_ff @(posedge single_clk) begin
    if (reset)        stack_level <= '0;
    else if (push_go) stack_level <= stack_level + LEVEL_ONE;
    else if (pop_go)  stack_level <= level_dec;
  end

  // Context storage carries no reset; only stack_level decides what is valid.
  always_ff @(posedge single_clk) begin
    if (push_go && !reset) begin
      stack_read[stack_level[PTR_W-1:0]]  <= read_bank;
      stack_write[stack_level[PTR_W-1:0]] <= write_bank;
    end
  end
`endif

endmodule

// File: tb/tb_address_bank_setter.sv
module tb_address_bank_setter;

  localparam logic [2:0] NOP = 3'd0, TOGW = 3'd1, SETW = 3'd2, TOGR = 3'd3;
  localparam logic [2:0] SETR = 3'd4, INC = 3'd5, PUSH = 3'd6, POP = 3'd7;
  localparam int SD = 4;
`ifdef ADDR_SETTER_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cmd_valid, err_clear;
  logic [2:0] cmd;
  logic [1:0] cmd_bank;

  logic [1:0] wb4, rb4, wb3, rb3;
  logic [2:0] lvl4, lvl3, err4, err3;
  logic       full4, empty4, full3, empty3;

  address_bank_setter #(.BANK_COUNT(4), .BANK_WIDTH(2), .STACK_DEPTH(SD), .DEPTH_WIDTH(3)) u_dut4 (
    .single_clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .err_clear(err_clear), .write_bank(wb4), .read_bank(rb4), .stack_level(lvl4),
    .stack_full(full4), .stack_empty(empty4), .err(err4));

  address_bank_setter #(.BANK_COUNT(3), .BANK_WIDTH(2), .STACK_DEPTH(SD), .DEPTH_WIDTH(3)) u_dut3 (
    .single_clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .err_clear(err_clear), .write_bank(wb3), .read_bank(rb3), .stack_level(lvl3),
    .stack_full(full3), .stack_empty(empty3), .err(err3));

  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] rb;
    logic [2:0] lvl;
    logic       full;
    logic       empty;
    logic [2:0] err;
  } obs_t;

  obs_t exp_q4[$];
  obs_t exp_q3[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: index 0 = 4-bank instance, index 1 = 3-bank instance.
  int       bc [2] = '{4, 3};
  int       m_wb [2], m_rb [2], m_lvl [2];
  bit [2:0] m_err [2];
  int       m_sr [2][SD];
  int       m_sw [2][SD];

  function automatic void model_step(int d);
    bit [2:0] ne;
    int t;
    int b;
    ne = 3'b000;
    b  = int'(cmd_bank);
    if (reset) begin
      m_wb[d] = 0; m_rb[d] = 0; m_lvl[d] = 0; m_err[d] = 3'b000;
      return;
    end
    if (cmd_valid) begin
      case (cmd)
        TOGW: begin t = m_wb[d] ^ 1; if (t < bc[d]) m_wb[d] = t; else ne[2] = 1'b1; end
        TOGR: begin t = m_rb[d] ^ 1; if (t < bc[d]) m_rb[d] = t; else ne[2] = 1'b1; end
        SETW: if (b < bc[d]) m_wb[d] = b; else ne[2] = 1'b1;
        SETR: if (b < bc[d]) m_rb[d] = b; else ne[2] = 1'b1;
        INC: begin
          m_wb[d] = (m_wb[d] + 1) % bc[d];
          m_rb[d] = (m_rb[d] + 1) % bc[d];
        end
        PUSH: if (STACK_EN) begin
          if (m_lvl[d] == SD) ne[0] = 1'b1;
          if (b >= bc[d])     ne[2] = 1'b1;
          if (ne == 3'b000) begin
            m_sr[d][m_lvl[d]] = m_rb[d];
            m_sw[d][m_lvl[d]] = m_wb[d];
            m_lvl[d] = m_lvl[d] + 1;
            m_rb[d] = b;
            m_wb[d] = b;
          end
        end
        POP: if (STACK_EN) begin
          if (m_lvl[d] == 0) ne[1] = 1'b1;
          else begin
            m_lvl[d] = m_lvl[d] - 1;
            m_rb[d] = m_sr[d][m_lvl[d]];
            m_wb[d] = m_sw[d][m_lvl[d]];
          end
        end
        default: ;
      endcase
    end
    m_err[d] = (err_clear ? 3'b000 : m_err[d]) | ne;
  endfunction

  function automatic obs_t model_obs(int d);
    obs_t o;
    o.wb    = 2'(m_wb[d]);
    o.rb    = 2'(m_rb[d]);
    o.lvl   = 3'(m_lvl[d]);
    o.full  = (m_lvl[d] == SD);
    o.empty = (m_lvl[d] == 0);
    o.err   = m_err[d];
    return o;
  endfunction

  function automatic obs_t dut_obs(int d);
    obs_t o;
    if (d == 0) o = '{wb: wb4, rb: rb4, lvl: lvl4, full: full4, empty: empty4, err: err4};
    else        o = '{wb: wb3, rb: rb3, lvl: lvl3, full: full3, empty: empty3, err: err3};
    return o;
  endfunction

  task automatic compare(input string name, input obs_t exp, input obs_t act);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got wb=%0d rb=%0d lvl=%0d full=%0b empty=%0b err=%b expected wb=%0d rb=%0d lvl=%0d full=%0b empty=%0b err=%b",
               name, act.wb, act.rb, act.lvl, act.full, act.empty, act.err,
               exp.wb, exp.rb, exp.lvl, exp.full, exp.empty, exp.err);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one command, let the model see the same edge, queue its expectation.
  task automatic step(input bit rst, input bit v, input logic [2:0] c, input logic [1:0] b, input bit clr);
    reset = rst; cmd_valid = v; cmd = c; cmd_bank = b; err_clear = clr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    exp_q4.push_back(model_obs(0));
    exp_q3.push_back(model_obs(1));
    @(negedge clk);
  endtask

  // Monitor: outputs are valid every cycle, so each queued expectation is consumed at the next falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q4.size() > 0) compare("sb_bank4", exp_q4.pop_front(), dut_obs(0));
      if (exp_q3.size() > 0) compare("sb_bank3", exp_q3.pop_front(), dut_obs(1));
    end
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = NOP; cmd_bank = 2'd0; err_clear = 1'b0;
    @(negedge clk);
    step(1, 0, NOP, 0, 0);
    step(1, 0, NOP, 0, 0);
    chk("reset_wb", int'(wb4), 0);
    chk("reset_rb", int'(rb4), 0);
    chk("reset_lvl", int'(lvl4), 0);
    chk("reset_empty", int'(empty4), 1);
    chk("reset_full", int'(full4), 0);
    chk("reset_err", int'(err4), 0);

    step(0, 1, TOGW, 0, 0);
    chk("tog1_wb", int'(wb4), 1); chk("tog1_rb", int'(rb4), 0);
    step(0, 1, TOGR, 0, 0);
    chk("tog2_wb", int'(wb4), 1); chk("tog2_rb", int'(rb4), 1);
    step(0, 1, TOGW, 0, 0);
    chk("tog3_wb", int'(wb4), 0); chk("tog3_rb", int'(rb4), 1);
    chk("tog3_err", int'(err4), 0);

    // Three-bank wrap and range error.
    step(0, 1, SETW, 2, 0);
    chk("set_wb3", int'(wb3), 2);
    step(0, 1, INC, 0, 0);
    chk("inc1_wb3", int'(wb3), 0);
    step(0, 1, INC, 0, 0);
    chk("inc2_wb3", int'(wb3), 1);
    chk("inc2_rb3", int'(rb3), 0);
    step(0, 1, SETR, 3, 0);
    chk("setr3_rb3", int'(rb3), 0);
    chk("setr3_err3", int'(err3), 4);
    chk("setr3_rb4", int'(rb4), 3);
    step(0, 0, NOP, 0, 1);
    chk("errclr_err3", int'(err3), 0);

    // Push/pop round trip; identical visible result with or without the stack.
    step(0, 1, SETR, 1, 0);
    step(0, 1, SETW, 2, 0);
    step(0, 1, PUSH, 3, 0);
    step(0, 1, POP, 0, 0);
    chk("pop_rb4", int'(rb4), 1);
    chk("pop_wb4", int'(wb4), 2);
    chk("pop_lvl4", int'(lvl4), 0);

    // Overflow then underflow.
    step(1, 0, NOP, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, PUSH, 2'(i + 1), 0);
`ifdef ADDR_SETTER_STACK_EN
    chk("ovf_lvl4", int'(lvl4), 4);
    chk("ovf_full4", int'(full4), 1);
    chk("ovf_err4", int'(err4), 1);
`else
    chk("nostk_lvl4", int'(lvl4), 0);
    chk("nostk_err4", int'(err4), 0);
`endif
    for (int i = 0; i < 5; i++) step(0, 1, POP, 0, 0);
`ifdef ADDR_SETTER_STACK_EN
    chk("unf_err4", int'(err4), 3);
    chk("unf_wb4", int'(wb4), 0);
`endif

    // Reset together with POP discards the stack.
    step(0, 1, PUSH, 1, 0);
    step(0, 1, PUSH, 2, 0);
    step(1, 1, POP, 0, 0);
    chk("rstpop_wb4", int'(wb4), 0);
    chk("rstpop_rb4", int'(rb4), 0);
    chk("rstpop_lvl4", int'(lvl4), 0);
    chk("rstpop_err4", int'(err4), 0);

    // PUSH 2 then POP returns to the same pointers with a clean error state.
    step(0, 1, PUSH, 2, 0);
    step(0, 1, POP, 0, 0);
    chk("pp_wb4", int'(wb4), 0);
    chk("pp_lvl4", int'(lvl4), 0);
    chk("pp_err4", int'(err4), 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end

    reset = 1'b0; cmd_valid = 1'b0; err_clear = 1'b0;
    for (int i = 0; i < 5 && (exp_q4.size() > 0 || exp_q3.size() > 0); i++) @(negedge clk);
    if (exp_q4.size() > 0 || exp_q3.size() > 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", exp_q4.size() + exp_q3.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
